wide_add_sequencer: RTL and testbench
=====================================

Name: wide_add_sequencer

Overview:
- Multi-cycle sequencer that computes a wide add/subtract of N*K bits by driving one external N-bit ripple_adder slice-by-slice, least-significant slice first.
- Chains the carry between slices in a register.
- Sits between the multiplier datapaths and a shared ripple_adder instance: wide accumulations without a K-times-wider carry chain.

Parameters:
- N, 32, width of the external adder slice in bits.
- K, 4, number of slices; operand/result width is N*K; K >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = A+B, 1 = A-B; captured with start
- op_a  input  N*K  operand A; captured with start
- op_b  input  N*K  operand B; captured with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- result  output  N*K  sum/difference register
- cout  output  1  carry out of MS slice (sub: 1 = no borrow)
- of  output  1  signed overflow of the full N*K operation
- add_in1  output  N  to adder in1
- add_in2  output  N  to adder in2
- add_cin  output  1  to adder cin
- add_s  input  N  from adder s
- add_cout  input  1  from adder cout
- add_of  input  1  from adder OF

Behaviour:
- Reset (async, rst_n=0): state=IDLE, slice index=0, carry reg=0, result=0, cout=0, of=0, done=0, busy=0. This takes effect immediately, including mid-operation; the operation in progress is abandoned with no done pulse.
- Adder drive:
  - add_in1 = A_reg slice[idx], add_in2 = B_reg slice[idx], add_cin = carry reg.
  - All three are 0 outside RUN.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: A_reg<=op_a; B_reg<=(sub ? ~op_b : op_b); carry reg<=sub; idx<=0; go to RUN.
  - Otherwise hold.
  - result/cout/of keep the previous values.
- RUN, each edge:
  - result slice[idx]<=add_s; carry reg<=add_cout.
  - If idx==K-1: cout<=add_cout; of<=add_of; idx<=0; go to DONE.
  - Otherwise idx<=idx+1.
- DONE: done=1 for exactly this one cycle; the next edge returns to IDLE unconditionally.
- Latency and throughput:
  - The start edge is E0; slices are captured at E1..EK; done is high between EK and EK+1.
  - With start held high, the next acceptance is at EK+2.
- start while busy (RUN or DONE) is ignored; op_a/op_b/sub may change freely after acceptance.
- Output visibility:
  - result is partially updated during RUN (lower slices new, upper slices old) and is valid from the done cycle until the next accepted start.
  - cout/of change only at the final RUN edge.
- Width rules:
  - Two's-complement arithmetic.
  - of is the MS slice's overflow flag: sign-in-equal, sign-out-different, using the inverted B for sub.
  - Lower-slice add_of values are ignored.
- K=1: a single RUN cycle, equivalent to one adder pass with registered outputs.

Test Plan:
- All tests use N=8, K=4.
1. Add 0x000000FF + 0x00000001 (start at E0) -> result=0x00000100, cout=0, of=0; done only between E4 and E5; busy high E0..E5.
2. Add 0xFFFFFFFF + 0x00000001 -> result=0x00000000, cout=1, of=0; checks the carry ripples through all 4 slices.
3. Add 0x7FFFFFFF + 0x00000001 -> result=0x80000000, of=1, cout=0. Add 0x80000000 + 0x80000000 -> result=0, of=1, cout=1.
4. Sub 0x00000000 - 0x00000001 -> result=0xFFFFFFFF, cout=0, of=0. Sub 0x80000000 - 0x00000001 -> result=0x7FFFFFFF, of=1, cout=1.
5. Pulse start again with different operands while in RUN -> ignored, first result intact. Then assert rst_n=0 between E2 and E3 of a new operation -> busy/done/result/cout/of=0 immediately, no done pulse. Release, start 0x00000010+0x00000020 -> result=0x00000030.
6. Hold start=1 continuously with fixed operands -> accepts at E0, E6, E12; done pulses between E4–E5 and E10–E11; add_in1/add_in2/add_cin are 0 during DONE and IDLE cycles.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer
//
// Computes an N*K-bit add or subtract by driving one external N-bit adder
// slice by slice, least-significant slice first. The carry between slices
// is kept in a register, so the wide operation needs no K-times-wider carry
// chain. Subtraction is A + ~B + 1: B is inverted at capture time and the
// initial carry is set to 1.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             request, sampled only while idle
//   sub               0 = A+B, 1 = A-B (captured with start)
//   op_a, op_b        N*K-bit operands (captured with start)
//   busy              high while running and during the done cycle
//   done              one-cycle completion pulse
//   result            sum/difference register (valid from done onward)
//   cout              carry out of the MS slice (sub: 1 = no borrow)
//   of                signed overflow of the full-width operation
//   add_in1/2, add_cin   drive to the external adder (zero when not running)
//   add_s, add_cout, add_of   response from the external adder
// ---------------------------------------------------------------------------
module wide_add_sequencer #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sub,
    input  logic [N*K-1:0] op_a,
    input  logic [N*K-1:0] op_b,
    output logic           busy,
    output logic           done,
    output logic [N*K-1:0] result,
    output logic           cout,
    output logic           of,
    output logic [N-1:0]   add_in1,
    output logic [N-1:0]   add_in2,
    output logic           add_cin,
    input  logic [N-1:0]   add_s,
    input  logic           add_cout,
    input  logic           add_of
);

    // Slice index width; a single-slice build still needs one index bit.
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            accept_s;
    logic            last_s;
    logic [IW-1:0]   idx_r;
    logic            carry_r;
    logic [N*K-1:0]  a_r;
    logic [N*K-1:0]  b_r;
    logic [N*K-1:0]  result_r;
    logic            cout_r;
    logic            of_r;

    // Extract the N-bit slice number i from a full-width vector.
    function automatic logic [N-1:0] get_slice(input logic [N*K-1:0] v,
                                               input logic [IW-1:0]  i);
        return v[i*N +: N];
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode plus the accept/last-slice strobes used by the datapath.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                    last_s  = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, slice walking, carry chaining and result collection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {(N*K){1'b0}};
            b_r      <= {(N*K){1'b0}};
            idx_r    <= {IW{1'b0}};
            carry_r  <= 1'b0;
            result_r <= {(N*K){1'b0}};
            cout_r   <= 1'b0;
            of_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r     <= op_a;
                        // Subtract as A + ~B + 1: invert now, seed carry with 1.
                        b_r     <= sub ? ~op_b : op_b;
                        carry_r <= sub;
                        idx_r   <= {IW{1'b0}};
                    end
                end
                ST_RUN: begin
                    result_r[idx_r*N +: N] <= add_s;
                    carry_r                <= add_cout;
                    if (last_s) begin
                        // Only the MS slice's flags describe the wide result.
                        cout_r <= add_cout;
                        of_r   <= add_of;
                        idx_r  <= {IW{1'b0}};
                    end else begin
                        idx_r  <= idx_r + IW'(1);
                    end
                end
                ST_DONE: begin
                    idx_r <= {IW{1'b0}};
                end
                default: begin
                    idx_r <= {IW{1'b0}};
                end
            endcase
        end
    end

    // Adder drive: current slice while running, quiet zeros otherwise.
    always_comb begin
        add_in1 = {N{1'b0}};
        add_in2 = {N{1'b0}};
        add_cin = 1'b0;
        if (state_r == ST_RUN) begin
            add_in1 = get_slice(a_r, idx_r);
            add_in2 = get_slice(b_r, idx_r);
            add_cin = carry_r;
        end else begin
            add_in1 = {N{1'b0}};
            add_in2 = {N{1'b0}};
            add_cin = 1'b0;
        end
    end

    // Status flags decode straight from the state register, so they carry no
    // combinational path from any input.
    assign busy   = (state_r == ST_RUN) || (state_r == ST_DONE);
    assign done   = (state_r == ST_DONE);
    assign result = result_r;
    assign cout   = cout_r;
    assign of     = of_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for wide_add_sequencer with N=8, K=4. The external
// ripple adder is modelled here as a plain N-bit add with carry and signed
// overflow. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_wide_add_sequencer;

    localparam int N = 8;
    localparam int K = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           sub;
    logic [N*K-1:0] op_a;
    logic [N*K-1:0] op_b;
    logic           busy;
    logic           done;
    logic [N*K-1:0] result;
    logic           cout;
    logic           of;
    logic [N-1:0]   add_in1;
    logic [N-1:0]   add_in2;
    logic           add_cin;
    logic [N-1:0]   add_s;
    logic           add_cout;
    logic           add_of;

    int total;
    int bad;

    wide_add_sequencer #(.N(N), .K(K)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .of       (of),
        .add_in1  (add_in1),
        .add_in2  (add_in2),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .add_of   (add_of)
    );

    // External ripple adder model.
    always_comb begin
        {add_cout, add_s} = {1'b0, add_in1} + {1'b0, add_in2} + {{N{1'b0}}, add_cin};
        add_of = (add_in1[N-1] == add_in2[N-1]) && (add_s[N-1] != add_in1[N-1]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request, let edge E0 accept it, and drop start again.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Full operation with timing checks around E0..E5.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] er, input logic ec,
                          input logic eo);
        logic [31:0] bb;
        bb = s ? ~b : b;
        launch(a, b, s);
        chk({tag, " busy@E0"}, 64'(busy), 64'd1);
        chk({tag, " done@E0"}, 64'(done), 64'd0);
        chk({tag, " in1 slice0"}, 64'(add_in1), 64'(a[7:0]));
        chk({tag, " in2 slice0"}, 64'(add_in2), 64'(bb[7:0]));
        chk({tag, " cin slice0"}, 64'(add_cin), 64'(s));
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            chk({tag, " done early"}, 64'(done), 64'd0);
            chk({tag, " busy run"}, 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        chk({tag, " done@E4"}, 64'(done), 64'd1);
        chk({tag, " busy@E4"}, 64'(busy), 64'd1);
        chk({tag, " result"}, 64'(result), 64'(er));
        chk({tag, " cout"}, 64'(cout), 64'(ec));
        chk({tag, " of"}, 64'(of), 64'(eo));
        chk({tag, " in1 idle"}, 64'(add_in1), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, " done@E5"}, 64'(done), 64'd0);
        chk({tag, " busy@E5"}, 64'(busy), 64'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #12;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst cout", 64'(cout), 64'd0);
        chk("rst of", 64'(of), 64'd0);
        chk("rst in1", 64'(add_in1), 64'd0);
        chk("rst cin", 64'(add_cin), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1..4: basic add/sub with carry and overflow corners
        run_op("t1 ff+1",   32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
        run_op("t2 ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op("t3 posov",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op("t3 negov",  32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
        run_op("t4 0-1",    32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("t4 min-1",  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

        // 5a: start pulsed during RUN must be ignored
        launch(32'h12345678, 32'h11111111, 1'b0);
        @(posedge clk);
        #1;
        op_a  = 32'hAAAAAAAA;
        op_b  = 32'h55555555;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t5 done", 64'(done), 64'd1);
        chk("t5 result kept", 64'(result), 64'h23456789);
        @(posedge clk);
        #1;
        chk("t5 idle after", 64'(busy), 64'd0);

        // 5b: reset between E2 and E3 abandons the operation
        launch(32'hFFFFFFFF, 32'h00000001, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5 rst busy", 64'(busy), 64'd0);
        chk("t5 rst done", 64'(done), 64'd0);
        chk("t5 rst result", 64'(result), 64'd0);
        chk("t5 rst cout", 64'(cout), 64'd0);
        chk("t5 rst of", 64'(of), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("t5 no done in rst", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5 no done after rst", 64'(done), 64'd0);
        run_op("t5 after rst", 32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0);

        // 6: start held high: accepts at E0, E6, E12
        op_a  = 32'h01020304;
        op_b  = 32'h10203040;
        sub   = 1'b0;
        start = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            int ph;
            logic [31:0] av;
            logic [31:0] bv;
            @(posedge clk);
            #1;
            ph = j % 6;
            av = op_a;
            bv = op_b;
            chk("t6 busy", 64'(busy), (ph != 5) ? 64'd1 : 64'd0);
            chk("t6 done", 64'(done), (ph == 4) ? 64'd1 : 64'd0);
            chk("t6 in1", 64'(add_in1), (ph <= 3) ? 64'(av[ph*8 +: 8]) : 64'd0);
            chk("t6 in2", 64'(add_in2), (ph <= 3) ? 64'(bv[ph*8 +: 8]) : 64'd0);
            if (ph >= 4) begin
                chk("t6 cin idle", 64'(add_cin), 64'd0);
            end
            if (ph == 4) begin
                chk("t6 result", 64'(result), 64'h11223344);
            end
        end
        start = 1'b0;
        for (int j = 13; j <= 17; j++) begin
            @(posedge clk);
            #1;
            chk("t6 tail done", 64'(done), (j == 16) ? 64'd1 : 64'd0);
        end
        chk("t6 tail idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
